// File: rtl/bound_flasher_pkg.sv
// Shared types and lamp bound constants for the bound flasher controller.
package bound_flasher_pkg;

   localparam int unsigned LED_NUM = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      S4   = 3'd4,
      S5   = 3'd5,
      S6   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_FILL  = 2'd1,
      OP_DRAIN = 2'd2,
      OP_CLEAR = 2'd3
   } shift_op_t;

   localparam logic [LED_NUM-1:0] LED_B5     = 16'h003F;
   localparam logic [LED_NUM-1:0] LED_B10    = 16'h07FF;
   localparam logic [LED_NUM-1:0] LED_B15    = 16'hFFFF;
   localparam logic [LED_NUM-1:0] LED_B5_OFF = 16'h001F;
   localparam logic [LED_NUM-1:0] LED_ZERO   = 16'h0000;

   // Lamp patterns at which a flick request can force an early turn-off.
   function automatic logic is_kick_point(input logic [LED_NUM-1:0] led);
      return (led == LED_B5) || (led == LED_B10);
   endfunction

endpackage

// File: rtl/bound_flasher_shifter.sv
// Lamp register: fills from the bottom, drains from the top, holds or clears.
module bound_flasher_shifter
   import bound_flasher_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  shift_op_t           op,
   output logic [LED_NUM-1:0]  led_state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_state <= LED_ZERO;
      end else begin
         case (op)
            OP_FILL:  led_state <= {led_state[LED_NUM-2:0], 1'b1};
            OP_DRAIN: led_state <= {1'b0, led_state[LED_NUM-1:1]};
            OP_CLEAR: led_state <= LED_ZERO;
            default:  led_state <= led_state;
         endcase
      end
   end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// 16-lamp bound flasher sequencer.
// Define BOUND_FLASHER_FLICK_SYNC_EN to pass flick through a 2-flop synchronizer.
module bound_flasher_ctrl
   import bound_flasher_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flick,
   output logic [LED_NUM-1:0]  led_state
);

   logic      flick_s;
   state_t    state;
   state_t    next_state_c;
   shift_op_t op_c;
   logic      kick_c;

`ifdef BOUND_FLASHER_FLICK_SYNC_EN
   logic [1:0] flick_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flick_sync <= 2'b00;
      end else begin
         flick_sync <= {flick_sync[0], flick};
      end
   end

   assign flick_s = flick_sync[1];
`else
   assign flick_s = flick;
`endif

   // Next state and lamp step; a bound switches state and takes the new state's first step.
   always_comb begin
      next_state_c = state;
      op_c         = OP_HOLD;
      kick_c       = flick_s && is_kick_point(led_state);
      case (state)
         IDLE: begin
            if (flick_s) begin
               next_state_c = S1;
               op_c         = OP_FILL;
            end else begin
               op_c = OP_CLEAR;
            end
         end
         S1: begin
            if (led_state == LED_B5) begin
               next_state_c = S2;
               op_c         = OP_DRAIN;
            end else begin
               op_c = OP_FILL;
            end
         end
         S2: begin
            if (led_state == LED_ZERO) begin
               next_state_c = S3;
               op_c         = OP_FILL;
            end else begin
               op_c = OP_DRAIN;
            end
         end
         S3: begin
            if (kick_c) begin
               next_state_c = S2;
               op_c         = OP_DRAIN;
            end else if (led_state == LED_B10) begin
               next_state_c = S4;
               op_c         = OP_DRAIN;
            end else begin
               op_c = OP_FILL;
            end
         end
         S4: begin
            if (led_state == LED_B5_OFF) begin
               next_state_c = S5;
               op_c         = OP_FILL;
            end else begin
               op_c = OP_DRAIN;
            end
         end
         S5: begin
            if (kick_c) begin
               next_state_c = S4;
               op_c         = OP_DRAIN;
            end else if (led_state == LED_B15) begin
               next_state_c = S6;
               op_c         = OP_DRAIN;
            end else begin
               op_c = OP_FILL;
            end
         end
         S6: begin
            if (led_state == LED_ZERO) begin
               next_state_c = IDLE;
               op_c         = OP_CLEAR;
            end else begin
               op_c = OP_DRAIN;
            end
         end
         default: begin
            next_state_c = IDLE;
            op_c         = OP_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state_c;
      end
   end

   bound_flasher_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op_c),
      .led_state (led_state)
   );

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Scoreboard bench for bound_flasher_ctrl against a lamp-count reference model.
module tb_bound_flasher_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flick;
   logic [15:0] led_state;

   int passed = 0;
   int total  = 0;

   logic [15:0] exp_q[$];

   // Reference model: phase 0 = idle, 1..6 = sequence legs; n = number of lit lamps.
   int phase = 0;
   int n     = 0;
   bit f_d1  = 1'b0;
   bit f_d2  = 1'b0;

   bound_flasher_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flick     (flick),
      .led_state (led_state)
   );

   always #5 clk = ~clk;

   function automatic int leg_target(input int p);
      case (p)
         1: return 6;
         2: return 0;
         3: return 11;
         4: return 5;
         5: return 16;
         default: return 0;
      endcase
   endfunction

   function automatic logic [15:0] lamps(input int k);
      return 16'((32'd1 << k) - 32'd1);
   endfunction

   task automatic model_step(input bit f);
      bit up;
      up = (phase % 2) == 1;
      if (phase == 0) begin
         if (f) begin
            phase = 1;
            n     = 1;
         end
      end else if (up) begin
         if ((phase == 3 || phase == 5) && f && (n == 6 || n == 11)) begin
            phase = phase - 1;
            n     = n - 1;
         end else if (n == leg_target(phase)) begin
            phase = phase + 1;
            n     = n - 1;
         end else begin
            n = n + 1;
         end
      end else begin
         if (n == leg_target(phase)) begin
            if (phase == 6) begin
               phase = 0;
            end else begin
               phase = phase + 1;
               n     = n + 1;
            end
         end else begin
            n = n - 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Model advances on every rising edge and queues the lamp vector it predicts.
   initial begin
      bit f;
      forever begin
         @(posedge clk);
         f = flick;
         if (!rst_n) begin
            phase = 0;
            n     = 0;
            f_d1  = 1'b0;
            f_d2  = 1'b0;
         end else begin
`ifdef BOUND_FLASHER_FLICK_SYNC_EN
            model_step(f_d2);
            f_d2 = f_d1;
            f_d1 = f;
`else
            model_step(f);
`endif
         end
         exp_q.push_back(lamps(n));
      end
   end

   // Monitor compares each predicted value away from the active edge.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_state", 32'(led_state), 32'(e));
         end
      end
   end

   initial begin
      logic [15:0] prev;
      int changes;
      int kicks;

      rst_n = 1'b0;
      flick = 1'bx;
      repeat (3) @(negedge clk);
      check("reset_value", 32'(led_state), 32'h0);
      rst_n = 1'b1;
      flick = 1'b0;
      repeat (4) @(negedge clk);

      // Single pulse: full sequence, count lamp changes.
      prev    = led_state;
      flick   = 1'b1;
      changes = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (i == 0) flick = 1'b0;
         if (led_state != prev) changes++;
         prev = led_state;
      end
      check("full_run_changes", 32'(changes), 32'd56);

      // Held flick: repeated kickback at the lamp-5 point in S3.
      flick = 1'b1;
      repeat (120) @(negedge clk);
      flick = 1'b0;
      repeat (90) @(negedge clk);

      // Kickback at lamp 10 in S5.
      kicks = 0;
      @(negedge clk);
      flick = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         flick = (phase == 5 && n == 11 && kicks == 0);
         if (flick) kicks++;
      end
      flick = 1'b0;
      repeat (10) @(negedge clk);

      // Flick held only where it must be ignored.
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         flick = (i == 0) || (phase == 1) || (phase == 2) || (phase == 4) || (phase == 6);
      end
      flick = 1'b0;
      repeat (20) @(negedge clk);

      // Random flick traffic.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         flick = ($urandom_range(0, 7) == 0);
      end
      flick = 1'b0;
      repeat (90) @(negedge clk);

      // Asynchronous reset in the middle of S3.
      @(negedge clk);
      flick = 1'b1;
      for (int i = 0; i < 100 && !(phase == 3 && n > 3); i++) @(negedge clk);
      check("reached_s3", 32'(phase), 32'd3);
      flick = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("async_reset", 32'(led_state), 32'h0);
      @(negedge clk);
      check("reset_hold", 32'(led_state), 32'h0);
      flick = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      flick = 1'b0;
      repeat (100) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
